// File: rtl/memory_embedded_arbiter_pkg.sv
// Shared definitions for the two-port embedded BRAM arbiter: FSM encodings,
// port indices and a helper for slicing per-port packed buses.
package memory_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic PORT_0 = 1'b0;
    localparam logic PORT_1 = 1'b1;

    // LSB position of a port's field inside a bus packed as {port1, port0}
    function automatic int unsigned slice_lsb(input logic port, input int unsigned width);
        return (port == PORT_1) ? width : 32'd0;
    endfunction

endpackage

// File: rtl/memory_embedded_arbiter_rr.sv
// Two-way round-robin grant: the port opposite the last grant wins a tie.
module rr_arbiter_2
    import memory_arbiter_pkg::*;
(
    input  logic [1:0] eligible,
    input  logic       last,
    output logic       grant,
    output logic       grant_valid
);

    // Pick the grant index from the eligible set and the last-grant pointer
    always_comb begin
        grant = PORT_0;
        case (eligible)
            2'b01:   grant = PORT_0;
            2'b10:   grant = PORT_1;
            2'b11:   grant = ~last;
            default: grant = PORT_0;
        endcase
    end

    assign grant_valid = |eligible;

endmodule

// File: rtl/memory_embedded_arbiter.sv
// Shares one single-port BRAM between two requesters with round-robin grant,
// range checking and a fixed IDLE -> ACCESS -> RESP access sequence.
module memory_embedded_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int N_ENTRIES = 16384,
    parameter int BW_DATA   = 32,
    parameter int BW_ADDR   = 16
) (
    input  logic                   clock_i,
    input  logic                   resetn_i,
    input  logic [1:0]             req_i,
    input  logic [1:0]             rw_i,
    input  logic [2*BW_ADDR-1:0]   addr_i,
    input  logic [2*BW_DATA-1:0]   data_i,
    output logic [2*BW_DATA-1:0]   data_o,
    output logic [1:0]             done_o,
    output logic [1:0]             err_o,
    output logic                   busy_o,
    output logic                   mem_wren_o,
    output logic [BW_ADDR-1:0]     mem_addr_o,
    output logic [BW_DATA-1:0]     mem_data_o,
    input  logic [BW_DATA-1:0]     mem_data_i
);

    // One extra bit so that N_ENTRIES = 2^BW_ADDR leaves every address in range
    localparam logic [BW_ADDR:0] N_LIMIT = (BW_ADDR+1)'(N_ENTRIES);

    state_t             state_r;
    logic               last_r;
    logic               gnt_r;
    logic               rw_r;
    logic               range_err_r;

    logic [1:0]         eligible_s;
    logic               gnt_idx_s;
    logic               gnt_valid_s;
    logic [BW_ADDR-1:0] addr_s;
    logic [BW_DATA-1:0] wdata_s;
    logic               range_err_s;

    // A port pulsing done is still dropping its request; keep it out of arbitration
    assign eligible_s = req_i & ~done_o;

    rr_arbiter_2 u_rr (
        .eligible    (eligible_s),
        .last        (last_r),
        .grant       (gnt_idx_s),
        .grant_valid (gnt_valid_s)
    );

    // Select the candidate port's address and write data, and range-check it
    always_comb begin
        addr_s      = addr_i[slice_lsb(gnt_idx_s, BW_ADDR) +: BW_ADDR];
        wdata_s     = data_i[slice_lsb(gnt_idx_s, BW_DATA) +: BW_DATA];
        range_err_s = ({1'b0, addr_s} >= N_LIMIT);
    end

    // Access sequencer with registered memory-side and requester-side outputs
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_r     <= ST_IDLE;
            last_r      <= PORT_1;
            gnt_r       <= PORT_0;
            rw_r        <= 1'b0;
            range_err_r <= 1'b0;
            data_o      <= '0;
            done_o      <= 2'b00;
            err_o       <= 2'b00;
            busy_o      <= 1'b0;
            mem_wren_o  <= 1'b0;
            mem_addr_o  <= '0;
            mem_data_o  <= '0;
        end else begin
            done_o <= 2'b00;
            case (state_r)
                ST_IDLE: begin
                    if (gnt_valid_s) begin
                        state_r     <= ST_ACCESS;
                        gnt_r       <= gnt_idx_s;
                        last_r      <= gnt_idx_s;
                        rw_r        <= rw_i[gnt_idx_s];
                        range_err_r <= range_err_s;
                        mem_addr_o  <= addr_s;
                        mem_data_o  <= wdata_s;
                        mem_wren_o  <= rw_i[gnt_idx_s] & ~range_err_s;
                        busy_o      <= 1'b1;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    mem_wren_o <= 1'b0;
                    state_r    <= ST_RESP;
                end
                ST_RESP: begin
                    if (!rw_r && !range_err_r) begin
                        data_o[slice_lsb(gnt_r, BW_DATA) +: BW_DATA] <= mem_data_i;
                    end
                    err_o[gnt_r]  <= range_err_r;
                    done_o[gnt_r] <= 1'b1;
                    busy_o        <= 1'b0;
                    state_r       <= ST_IDLE;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    mem_wren_o <= 1'b0;
                    busy_o     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_embedded_arbiter.sv
// Scoreboard bench: stimulus pushes expected completions, a negedge monitor
// pops and compares them whenever done_o pulses.
module tb_memory_embedded_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [1:0]  rw = 2'b00;
    logic [31:0] addr = 32'd0;
    logic [63:0] wdata = 64'd0;
    logic [63:0] data_o;
    logic [1:0]  done;
    logic [1:0]  err;
    logic        busy;
    logic        mem_wren;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_q;

    logic [31:0] mem [0:65535];
    logic [15:0] addr_q = 16'd0;

    typedef struct {
        logic        port;
        logic        err;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];

    int n_pass = 0;
    int n_total = 0;
    int wren_cnt = 0;

    memory_embedded_arbiter #(.N_ENTRIES(1024), .BW_DATA(32), .BW_ADDR(16)) dut (
        .clock_i    (clk),
        .resetn_i   (rst_n),
        .req_i      (req),
        .rw_i       (rw),
        .addr_i     (addr),
        .data_i     (wdata),
        .data_o     (data_o),
        .done_o     (done),
        .err_o      (err),
        .busy_o     (busy),
        .mem_wren_o (mem_wren),
        .mem_addr_o (mem_addr),
        .mem_data_o (mem_wdata),
        .mem_data_i (mem_q)
    );

    always #5 clk = ~clk;

    // BRAM model: registered address/data/we, unregistered q
    always @(posedge clk) begin
        if (mem_wren) mem[mem_addr] <= mem_wdata;
        addr_q <= mem_addr;
    end
    assign mem_q = mem[addr_q];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: compare each done pulse against the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_wren) wren_cnt++;
            if (done !== 2'b00) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", {62'd0, done}, 64'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("done_port", {62'd0, done}, e.port ? 64'd2 : 64'd1);
                    check("err", {63'd0, err[e.port]}, {63'd0, e.err});
                    check("data", {32'd0, data_o[int'(e.port)*32 +: 32]}, {32'd0, e.data});
                end
            end
        end
    end

    task automatic single_op(input logic p, input logic w, input logic [15:0] a,
                             input logic [31:0] wd, input logic e_err,
                             input logic [31:0] e_data, input int e_wr, input string tag);
        int cyc;
        int wr0;
        cyc = 0;
        wr0 = wren_cnt;
        sb_q.push_back('{port: p, err: e_err, data: e_data});
        rw[p] = w;
        addr[int'(p)*16 +: 16] = a;
        wdata[int'(p)*32 +: 32] = wd;
        req[p] = 1'b1;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check({tag, "_mem_addr"}, {48'd0, mem_addr}, {48'd0, a});
        end while (done[p] !== 1'b1 && cyc < 20);
        req[p] = 1'b0;
        check({tag, "_latency"}, 64'(cyc), 64'd3);
        @(negedge clk);
        check({tag, "_wren_cycles"}, 64'(wren_cnt - wr0), 64'(e_wr));
    endtask

    initial begin
        int cyc;
        int n_done;
        int exp_cyc;
        for (int i = 0; i < 65536; i++) mem[i] = 32'd0;
        mem[16'h0010] = 32'hDEADBEEF;
        mem[16'h03FF] = 32'hCAFEF00D;
        repeat (3) @(negedge clk);
        check("rst_busy_done_err_wren", {58'd0, busy, done, err, mem_wren}, 64'd0);
        check("rst_data_o", data_o, 64'd0);
        check("rst_mem_bus", {16'd0, mem_addr, mem_wdata}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        single_op(1'b0, 1'b0, 16'h0010, 32'd0, 1'b0, 32'hDEADBEEF, 0, "p0_read");
        single_op(1'b1, 1'b1, 16'h0100, 32'h12345678, 1'b0, 32'd0, 1, "p1_write");
        single_op(1'b1, 1'b0, 16'h0100, 32'd0, 1'b0, 32'h12345678, 0, "p1_read");
        single_op(1'b0, 1'b1, 16'h0400, 32'h55555555, 1'b1, 32'hDEADBEEF, 0, "p0_oor_write");
        single_op(1'b0, 1'b0, 16'h03FF, 32'd0, 1'b0, 32'hCAFEF00D, 0, "p0_edge_read");

        // Reset during ACCESS of a write
        rw[0] = 1'b1;
        addr[15:0] = 16'h0010;
        wdata[31:0] = 32'hAAAA5555;
        req[0] = 1'b1;
        @(posedge clk);
        #1 check("rstmid_wren_before", {63'd0, mem_wren}, 64'd1);
        #1 rst_n = 1'b0;
        #1 check("rstmid_after", {61'd0, mem_wren, busy, |done}, 64'd0);
        @(negedge clk);
        req = 2'b00;
        rw = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rstmid_data_o", data_o, 64'd0);

        // Contention from reset, both ports re-requesting continuously
        addr = {16'h0100, 16'h0010};
        for (int k = 0; k < 3; k++) begin
            sb_q.push_back('{port: 1'b0, err: 1'b0, data: 32'hDEADBEEF});
            sb_q.push_back('{port: 1'b1, err: 1'b0, data: 32'h12345678});
        end
        req = 2'b11;
        cyc = 0;
        n_done = 0;
        exp_cyc = 3;
        while (n_done < 6 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done !== 2'b00) begin
                check("contention_done_cycle", 64'(cyc), 64'(exp_cyc));
                exp_cyc += 3;
                n_done++;
            end
        end
        req = 2'b00;
        check("contention_done_count", 64'(n_done), 64'd6);
        repeat (2) @(negedge clk);

        // Done masking: port 0 holds req one cycle past its done
        sb_q.push_back('{port: 1'b0, err: 1'b0, data: 32'hCAFEF00D});
        addr[15:0] = 16'h03FF;
        req[0] = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (done[0] !== 1'b1 && cyc < 20);
        check("mask_latency", 64'(cyc), 64'd3);
        @(negedge clk);
        check("mask_no_regrant_busy", {63'd0, busy}, 64'd0);
        req[0] = 1'b0;
        repeat (8) @(negedge clk);

        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
